// File: rtl/fake_mario_onchip_memory_arbiter.sv
// Round-robin two-master Avalon-MM arbiter in front of a single-port on-chip RAM.
// Latency: grant in the request cycle, read data + readdatavalid one cycle later.
// Backpressure: the losing master sees waitrequest=1 and holds; worst-case wait is 1 cycle.
module fake_mario_onchip_memory_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic req0, req1;
  logic gnt_vld, gnt_idx, gnt_wr, gnt_rd;
  logic last_q, last_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_tag_q, rd_tag_d;

  // Grant decision: a lone requester wins; on contention the master that was not served last wins.
  always_comb begin
    req0    = m0_read | m0_write;
    req1    = m1_read | m1_write;
    gnt_vld = ~reset & (req0 | req1);
    gnt_idx = (req0 & req1) ? ~last_q : req1;
    gnt_wr  = gnt_idx ? m1_write : m0_write;
    // write dominates an illegal read+write pair, so any non-write grant is a read
    gnt_rd  = gnt_vld & ~gnt_wr;
  end

  // Memory-side mux and per-master handshake; nothing here depends on mem_readdata.
  always_comb begin
    mem_address    = gnt_idx ? m1_address    : m0_address;
    mem_byteenable = gnt_idx ? m1_byteenable : m0_byteenable;
    mem_writedata  = gnt_idx ? m1_writedata  : m0_writedata;
    mem_chipselect = gnt_vld;
    mem_write      = gnt_vld & gnt_wr;
    mem_clken      = ~reset;
    m0_waitrequest = ~(gnt_vld & ~gnt_idx);
    m1_waitrequest = ~(gnt_vld &  gnt_idx);
  end

  // Read return: data fans out to both masters, the pending tag picks who sees the valid strobe.
  always_comb begin
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
    m0_readdatavalid = ~reset & rd_pend_q & ~rd_tag_q;
    m1_readdatavalid = ~reset & rd_pend_q &  rd_tag_q;
  end

  // Next state for the round-robin pointer and the one-deep read-tag pipeline.
  always_comb begin
    last_d    = gnt_vld ? gnt_idx : last_q;
    rd_pend_d = gnt_rd;
    rd_tag_d  = gnt_rd ? gnt_idx : rd_tag_q;
  end

  // State registers; reset makes master 0 the first contention winner and drops any in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q    <= 1'b1;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= 1'b0;
    end else begin
      last_q    <= last_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

endmodule

// File: tb/tb_fake_mario_onchip_memory_arbiter.sv
module tb_fake_mario_onchip_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [1:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata;

  logic        mem_init;
  logic [31:0] mem [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fake_mario_onchip_memory_arbiter #(.ADDR_W(2), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // 4x32 single-port RAM with registered read output and byte-lane writes
  always @(posedge clk) begin
    if (mem_init) begin
      mem[0] <= 32'h11110000;
      mem[1] <= 32'hAAAAAAAA;
      mem[2] <= 32'hCAFE0002;
      mem[3] <= 32'h33330003;
      mem_readdata <= 32'h0;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= mem[mem_address];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m0_address = 0; m0_byteenable = 4'hF; m0_writedata = 0;
    m1_read = 0; m1_write = 0; m1_address = 0; m1_byteenable = 4'hF; m1_writedata = 0;
  endtask

  task automatic test_reset();
    reset = 1; mem_init = 1;
    idle_inputs();
    m0_read = 1; m1_read = 1;   // requests must be ignored under reset
    next_cycle(); next_cycle();
    @(negedge clk);
    checks++;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      errors++; $display("FAIL reset_waitrequest: got m0=%b m1=%b expected 1 1", m0_waitrequest, m1_waitrequest);
    end
    checks++;
    if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_clken !== 1'b0) begin
      errors++; $display("FAIL reset_mem_ctrl: got cs=%b wr=%b clken=%b expected 0 0 0", mem_chipselect, mem_write, mem_clken);
    end
    checks++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b %b expected 0 0", m0_readdatavalid, m1_readdatavalid);
    end
    next_cycle();
    reset = 0; mem_init = 0;
    idle_inputs();
    @(negedge clk);
    checks++;
    if (mem_clken !== 1'b1 || mem_chipselect !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got clken=%b cs=%b expected 1 0", mem_clken, mem_chipselect);
    end
  endtask

  task automatic test_single_read();
    next_cycle();
    m0_read = 1; m0_address = 2'd2;
    @(negedge clk);
    checks++;
    if (m0_waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_address !== 2'd2 || mem_write !== 1'b0) begin
      errors++; $display("FAIL single_read_grant: got wait=%b cs=%b addr=%0d wr=%b expected 0 1 2 0",
                         m0_waitrequest, mem_chipselect, mem_address, mem_write);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hCAFE0002) begin
      errors++; $display("FAIL single_read_data: got vld=%b data=%h expected 1 cafe0002", m0_readdatavalid, m0_readdata);
    end
    checks++;
    if (m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL single_read_other: got m1 vld=%b expected 0", m1_readdatavalid);
    end
  endtask

  task automatic test_m1_read();
    next_cycle();
    m1_read = 1; m1_address = 2'd3;
    @(negedge clk);
    checks++;
    if (m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1 || mem_address !== 2'd3) begin
      errors++; $display("FAIL m1_read_grant: got w1=%b w0=%b addr=%0d expected 0 1 3", m1_waitrequest, m0_waitrequest, mem_address);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h33330003 || m0_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL m1_read_data: got v1=%b data=%h v0=%b expected 1 33330003 0",
                         m1_readdatavalid, m1_readdata, m0_readdatavalid);
    end
    next_cycle();   // idle gap so the contention run starts clean
  endtask

  task automatic test_back_to_back();
    m0_read = 1; m0_address = 2'd0;
    m1_read = 1; m1_address = 2'd3;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) idle_inputs();
      @(negedge clk);
      if (k < 4) begin
        checks++;
        if (m0_waitrequest !== k[0] || m1_waitrequest !== ~k[0]) begin
          errors++; $display("FAIL rr_grant[%0d]: got w0=%b w1=%b expected %b %b", k, m0_waitrequest, m1_waitrequest, k[0], ~k[0]);
        end
      end
      checks++;
      if (k == 0) begin
        if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
          errors++; $display("FAIL rr_valid[0]: got %b %b expected 0 0", m0_readdatavalid, m1_readdatavalid);
        end
      end else if (k[0]) begin
        if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== 32'h11110000) begin
          errors++; $display("FAIL rr_valid[%0d]: got v0=%b v1=%b data=%h expected 1 0 11110000",
                             k, m0_readdatavalid, m1_readdatavalid, m0_readdata);
        end
      end else begin
        if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdata !== 32'h33330003) begin
          errors++; $display("FAIL rr_valid[%0d]: got v0=%b v1=%b data=%h expected 0 1 33330003",
                             k, m0_readdatavalid, m1_readdatavalid, m1_readdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_write_then_read();
    m1_write = 1; m1_address = 2'd1; m1_byteenable = 4'b0011; m1_writedata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (m1_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_byteenable !== 4'b0011 || mem_writedata !== 32'h12345678) begin
      errors++; $display("FAIL write_grant: got w1=%b wr=%b be=%b wd=%h expected 0 1 0011 12345678",
                         m1_waitrequest, mem_write, mem_byteenable, mem_writedata);
    end
    next_cycle();
    idle_inputs();
    m0_read = 1; m0_address = 2'd1;
    @(negedge clk);
    checks++;
    if (m0_waitrequest !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL raw_grant: got w0=%b v1=%b expected 0 0", m0_waitrequest, m1_readdatavalid);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hAAAA5678) begin
      errors++; $display("FAIL raw_data: got vld=%b data=%h expected 1 aaaa5678", m0_readdatavalid, m0_readdata);
    end
    next_cycle();
  endtask

  task automatic test_contend_write_read();
    // last grant was m0, so m1 wins the first contested cycle
    m0_write = 1; m0_address = 2'd0; m0_writedata = 32'hDEADBEEF;
    m1_read = 1; m1_address = 2'd2;
    @(negedge clk);
    checks++;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b0 || mem_write !== 1'b0 || mem_address !== 2'd2) begin
      errors++; $display("FAIL contend_first: got w0=%b w1=%b wr=%b addr=%0d expected 1 0 0 2",
                         m0_waitrequest, m1_waitrequest, mem_write, mem_address);
    end
    next_cycle();
    m1_read = 0;   // m0 holds its write unchanged
    @(negedge clk);
    checks++;
    if (m0_waitrequest !== 1'b0 || mem_write !== 1'b1 || mem_writedata !== 32'hDEADBEEF || mem_address !== 2'd0) begin
      errors++; $display("FAIL contend_second: got w0=%b wr=%b wd=%h addr=%0d expected 0 1 deadbeef 0",
                         m0_waitrequest, mem_write, mem_writedata, mem_address);
    end
    checks++;
    if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hCAFE0002 || m0_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL contend_rdata: got v1=%b data=%h v0=%b expected 1 cafe0002 0",
                         m1_readdatavalid, m1_readdata, m0_readdatavalid);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL write_no_response: got %b %b expected 0 0", m0_readdatavalid, m1_readdatavalid);
    end
    next_cycle();
  endtask

  task automatic test_reset_discard();
    m0_read = 1; m0_address = 2'd2;
    @(negedge clk);
    checks++;
    if (m0_waitrequest !== 1'b0) begin
      errors++; $display("FAIL discard_grant: got w0=%b expected 0", m0_waitrequest);
    end
    next_cycle();
    idle_inputs();
    reset = 1;
    m0_read = 1; m1_read = 1;
    @(negedge clk);
    checks++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL discard_valid: got %b %b expected 0 0", m0_readdatavalid, m1_readdatavalid);
    end
    checks++;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || mem_clken !== 1'b0) begin
      errors++; $display("FAIL discard_wait: got w0=%b w1=%b clken=%b expected 1 1 0", m0_waitrequest, m1_waitrequest, mem_clken);
    end
    next_cycle();
    reset = 0;
    m0_address = 2'd0; m1_address = 2'd2;
    @(negedge clk);
    checks++;
    if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1 || m0_readdatavalid !== 1'b0) begin
      errors++; $display("FAIL post_reset_rr: got w0=%b w1=%b v0=%b expected 0 1 0", m0_waitrequest, m1_waitrequest, m0_readdatavalid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (m1_waitrequest !== 1'b0 || m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL post_reset_data: got w1=%b v0=%b data=%h expected 0 1 deadbeef",
                         m1_waitrequest, m0_readdatavalid, m0_readdata);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hCAFE0002) begin
      errors++; $display("FAIL post_reset_m1: got v1=%b data=%h expected 1 cafe0002", m1_readdatavalid, m1_readdata);
    end
    next_cycle();
  endtask

  task automatic test_idle();
    idle_inputs();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (mem_chipselect !== 1'b0 || m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
        errors++; $display("FAIL idle[%0d]: got cs=%b v0=%b v1=%b expected 0 0 0", k, mem_chipselect, m0_readdatavalid, m1_readdatavalid);
      end
      next_cycle();
    end
  endtask

  initial begin
    reset = 1; mem_init = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_m1_read();
    test_back_to_back();
    test_write_then_read();
    test_contend_write_read();
    test_reset_discard();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
